// File: rtl/dtw_pkg.sv
// Shared types for the DTW traceback block: direction codes, FSM states and width helpers.
// Pure declarations, so it adds no latency and applies no backpressure.
package dtw_pkg;

    typedef enum logic [1:0] {
        DIAG    = 2'd0,
        LEFT    = 2'd1,
        UP      = 2'd2,
        ILLEGAL = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_READ = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_e;

    function automatic int round_w(input int seq_len);
        return $clog2(2 * seq_len - 1);
    endfunction

    function automatic int coord_w(input int seq_len);
        return $clog2(seq_len);
    endfunction

    function automatic int len_w(input int seq_len);
        return $clog2(2 * seq_len);
    endfunction

endpackage

// File: rtl/dtw_step_calc.sv
// Combinational one-step traceback: next (x,y) and round from a direction code, with an error flag.
// Zero latency and no flow control; the caller decides when the step is taken.
module dtw_step_calc
    import dtw_pkg::*;
#(
    parameter int SEQ_LEN = 20,
    parameter int LANES   = 6,
    localparam int RW     = round_w(SEQ_LEN),
    localparam int CW     = coord_w(SEQ_LEN)
) (
    input  logic [CW-1:0] cur_x,
    input  logic [CW-1:0] cur_y,
    input  logic [RW-1:0] cur_round,
    input  dir_e          code,
    output logic [CW-1:0] nxt_x,
    output logic [CW-1:0] nxt_y,
    output logic [RW-1:0] nxt_round,
    output logic          step_err
);

    logic bad_move;
    int   nxt_lane;

    always_comb begin
        nxt_x     = cur_x;
        nxt_y     = cur_y;
        nxt_round = cur_round;
        bad_move  = 1'b0;
        case (code)
            DIAG: begin
                if (cur_x == '0 || cur_y == '0) begin
                    bad_move = 1'b1;
                end else begin
                    nxt_x     = cur_x - CW'(1);
                    nxt_y     = cur_y - CW'(1);
                    nxt_round = cur_round - RW'(2);
                end
            end
            LEFT: begin
                if (cur_x == '0) begin
                    bad_move = 1'b1;
                end else begin
                    nxt_x     = cur_x - CW'(1);
                    nxt_round = cur_round - RW'(1);
                end
            end
            UP: begin
                if (cur_y == '0) begin
                    bad_move = 1'b1;
                end else begin
                    nxt_y     = cur_y - CW'(1);
                    nxt_round = cur_round - RW'(1);
                end
            end
            default: bad_move = 1'b1;
        endcase
        // Band membership is judged on the destination cell.
        nxt_lane = int'(nxt_x) - int'(nxt_y) + LANES / 2;
        step_err = bad_move || (nxt_lane < 0) || (nxt_lane >= LANES);
    end

endmodule

// File: rtl/dtw_path_tracker_p.sv
// DTW band traceback: stores direction codes per anti-diagonal round, then streams the path from (N-1,N-1) to (0,0).
// Two cycles per beat (RAM read then emit); each beat holds until path_ready, stalls of any length allowed.
module dtw_path_tracker_p
    import dtw_pkg::*;
#(
    parameter int SEQ_LEN = 20,
    parameter int LANES   = 6,
    parameter int CODE_W  = 2,
    localparam int RW     = round_w(SEQ_LEN),
    localparam int CW     = coord_w(SEQ_LEN),
    localparam int LW     = len_w(SEQ_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    wr_valid,
    input  logic [RW-1:0]           wr_round,
    input  logic [LANES*CODE_W-1:0] wr_codes,
    input  logic                    finish,
    output logic [CW-1:0]           path_x,
    output logic [CW-1:0]           path_y,
    output logic                    path_valid,
    input  logic                    path_ready,
    output logic                    path_last,
    output logic [LW-1:0]           path_len,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int              DEPTH     = 2 * SEQ_LEN - 1;
    localparam int              DW        = LANES * CODE_W;
    localparam logic [CW-1:0]   MAX_XY    = CW'(SEQ_LEN - 1);
    localparam logic [RW-1:0]   MAX_ROUND = RW'(DEPTH - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   x_q, x_d, y_q, y_d;
    logic [RW-1:0]   round_q, round_d;
    logic [LW-1:0]   len_q, len_d;

    logic [DW-1:0]   mem [DEPTH];
    logic [DW-1:0]   rd_dat_q;
    logic            wr_en;
    int              cur_lane;
    logic [CODE_W-1:0] cell_code;
    logic [CW-1:0]   nxt_x, nxt_y;
    logic [RW-1:0]   nxt_round;
    logic            step_err;
    logic            at_origin;

    assign wr_en = !rst && (state_q == S_FILL) && wr_valid && (wr_round <= MAX_ROUND);

    // Code RAM is deliberately outside reset; it is always refilled before use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_round] <= wr_codes;
        end
        rd_dat_q <= mem[round_q];
    end

    always_comb begin
        cur_lane  = int'(x_q) - int'(y_q) + LANES / 2;
        cell_code = '1;
        if (cur_lane >= 0 && cur_lane < LANES) begin
            cell_code = rd_dat_q[cur_lane*CODE_W +: CODE_W];
        end
    end

    dtw_step_calc #(
        .SEQ_LEN (SEQ_LEN),
        .LANES   (LANES)
    ) u_step (
        .cur_x     (x_q),
        .cur_y     (y_q),
        .cur_round (round_q),
        .code      (dir_e'(cell_code[1:0])),
        .nxt_x     (nxt_x),
        .nxt_y     (nxt_y),
        .nxt_round (nxt_round),
        .step_err  (step_err)
    );

    assign at_origin = (x_q == '0) && (y_q == '0);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        round_d = round_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: ;
            S_FILL: if (finish) state_d = S_READ;
            S_READ: state_d = S_EMIT;
            S_EMIT: begin
                if (path_ready) begin
                    len_d = len_q + LW'(1);
                    if (at_origin) begin
                        state_d = S_DONE;
                    end else if (step_err) begin
                        state_d = S_ERR;
                    end else begin
                        x_d     = nxt_x;
                        y_d     = nxt_y;
                        round_d = nxt_round;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE, S_ERR: ;
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            state_d = S_FILL;
            x_d     = MAX_XY;
            y_d     = MAX_XY;
            round_d = MAX_ROUND;
            len_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= MAX_XY;
            y_q     <= MAX_XY;
            round_q <= MAX_ROUND;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            round_q <= round_d;
            len_q   <= len_d;
        end
    end

    assign path_x     = x_q;
    assign path_y     = y_q;
    assign path_valid = (state_q == S_EMIT);
    assign path_last  = path_valid && at_origin;
    assign path_len   = len_q;
    assign busy       = (state_q == S_READ) || (state_q == S_EMIT);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);

endmodule

// File: doc/dtw_path_tracker_p.md
DTW_PATH_TRACKER_P -- requirements
Module: dtw_path_tracker_p

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 20, the sequence length per axis; path coordinates run 0..SEQ_LEN-1.
REQ-002 SHALL have parameter LANES, default 6, even, the number of band cells stored per anti-diagonal round.
REQ-003 SHALL have parameter CODE_W, default 2, the direction-code width per cell.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, a pulse that opens a new fill phase.
REQ-007 SHALL have port wr_valid, input, 1, which qualifies a round write.
REQ-008 SHALL have port wr_round, input, RW=clog2(2*SEQ_LEN-1), the anti-diagonal round index r=x+y.
REQ-009 SHALL have port wr_codes, input, LANES*CODE_W, the codes for lanes 0..LANES-1, with lane 0 in the LSBs.
REQ-010 SHALL have port finish, input, 1, a pulse that ends fill and launches traceback.
REQ-011 SHALL have ports path_x and path_y, output, CW=clog2(SEQ_LEN), the current path coordinate.
REQ-012 SHALL have ports path_valid (output, 1), path_ready (input, 1) and path_last (output, 1), forming a valid/ready coordinate stream whose final beat is (0,0).
REQ-013 SHALL have port path_len, output, clog2(2*SEQ_LEN), the count of accepted beats.
REQ-014 SHALL have ports busy, done and err, output, 1 each, as status flags.

Function
REQ-015 SHALL map cell (x,y) to round x+y and lane x-y+LANES/2; any cell with lane outside 0..LANES-1 is out of band.
REQ-016 SHALL decode direction codes as 0 = diagonal (x-1,y-1; round-=2), 1 = left (x-1; round-=1), 2 = up (y-1; round-=1), 3 = illegal.
REQ-017 SHALL implement FSM states IDLE, FILL, READ, EMIT, DONE and ERR.
REQ-018 SHALL move IDLE->FILL on start, FILL->READ on finish, READ->EMIT after exactly 1 cycle (synchronous RAM read), EMIT->READ on a path_ready handshake that is not last, and EMIT->DONE on the handshake of the last beat.
REQ-019 SHALL, from DONE or ERR, move to FILL on start; start from any other state SHALL return the FSM to FILL and clear path_len, done and err.
REQ-020 SHALL accept writes only in FILL; a write in any other state is ignored; a repeat write to the same round overwrites, last write wins.
REQ-021 SHALL, when finish and wr_valid coincide in FILL, commit the write first and then enter READ.
REQ-022 SHALL begin traceback at (SEQ_LEN-1, SEQ_LEN-1), which is always the first beat.
REQ-023 SHALL hold path_valid high only in EMIT, and hold path_x and path_y stable until the handshake completes; backpressure may last any number of cycles.
REQ-024 SHALL assert path_last with the (0,0) beat; path_len increments by 1 per handshake and is not cleared in DONE.
REQ-025 SHALL enter ERR, raise err, and emit no further beats when a step would leave the band, the code is 3, code 1 is seen at x=0, or code 2 is seen at y=0.
REQ-026 SHALL set busy = state in {READ, EMIT}, and hold done high in DONE only.
REQ-027 SHALL NOT evaluate the code at (0,0); that beat is terminal.
REQ-028 SHALL keep path_len saturating-safe: the maximum legal path is 2*SEQ_LEN-1 beats, which fits the declared width.

Reset
REQ-029 SHALL, on rst, set state=IDLE, path_valid=0, path_last=0, path_x=path_y=SEQ_LEN-1, path_len=0, busy=0, done=0 and err=0.
REQ-030 SHALL let rst override start, finish and any handshake in the same cycle, including mid-traceback.
REQ-031 SHALL leave code RAM contents uninitialised by rst; the bench reads only rounds written since the last start.

Structure
REQ-032 SHALL place the direction-code enum (DIAG, LEFT, UP, ILLEGAL), the FSM state typedef and the width helper functions in shared package dtw_pkg.
REQ-033 SHALL use one sub-module, dtw_step_calc: combinational next-(x,y), round decrement and error flag from the current (x,y) and the selected code.
REQ-034 SHALL implement code storage as a 2*SEQ_LEN-1 by LANES*CODE_W single-write, single-read synchronous RAM inside the block.

Verification
REQ-035 SHALL cover: defaults, all rounds filled with code 0, path_ready held 1 -> 20 beats (19,19)..(0,0), path_last on the 20th beat, path_len=20, done=1.
REQ-036 SHALL cover: codes forcing an alternating left/up staircase within band -> 39 beats and path_len=39.
REQ-037 SHALL cover: path_ready toggled randomly at 50% -> the same beat sequence as REQ-035, with coordinates stable throughout every stall.
REQ-038 SHALL cover: round 38 lane 3 code=3 -> exactly 1 beat (19,19), then err=1, path_valid=0 and done=0.
REQ-039 SHALL cover: codes 1 repeated to drive x-y below -3 -> err asserted on the first out-of-band step.
REQ-040 SHALL cover: rst pulsed at beat 7 -> all reset values next cycle, and a following start/fill/finish completes normally.
